// File: rtl/encoder_pkg.sv
// Shared sizes, types and FSM encoding for the rank-order spike encoder.
`timescale 1ns/1ps
package encoder_pkg;

   localparam int IMAGE_SIZE      = 256;
   localparam int IMAGE_SIZE_BITS = 8;
   localparam int PIXEL_MAX_VALUE = 255;
   localparam int PIXEL_BITS      = 8;

   typedef logic [PIXEL_BITS:0]      pixel_t;
   typedef logic [IMAGE_SIZE_BITS:0] addr_t;

   typedef enum logic [2:0] {
      IDLE,
      HIST,
      PREFIX,
      PLACE,
      DONE_SORT,
      EMIT,
      WAIT_ACK_HI,
      WAIT_ACK_LO
   } enc_state_e;

endpackage

// File: rtl/aer_ack_sync.sv
// Two-flop synchronizer bringing the asynchronous AER acknowledge into the clock domain.
`timescale 1ns/1ps
module aer_ack_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ack_i,
   output logic ack_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= ack_i;
         sync_q <= meta_q;
      end
   end

   assign ack_o = sync_q;

endmodule

// File: rtl/rank_order_encoder.sv
// Rank-order encoder: counting-sorts a captured image by intensity and emits
// one AER event per non-zero pixel, brightest first, over a 4-phase link.
`timescale 1ns/1ps
module rank_order_encoder
   import encoder_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  pixel_t     IMAGE [IMAGE_SIZE],
   input  logic       NEW_IMAGE,
   input  logic       INFERENCE_DONE,
   output logic       IMAGE_ENCODED,
   output addr_t      AERIN_ADDR,
   output logic       AERIN_REQ,
   input  logic       AERIN_ACK,
   output enc_state_e dbg_state_o
);

   localparam int CIDX_W = $clog2(PIXEL_MAX_VALUE + 1);

   typedef logic [IMAGE_SIZE_BITS-1:0] idx_t;
   typedef logic [CIDX_W-1:0]          lvl_t;

   enc_state_e state_q, state_d;

   pixel_t pix_q   [IMAGE_SIZE];
   addr_t  count_q [PIXEL_MAX_VALUE+1];
   addr_t  start_q [PIXEL_MAX_VALUE+1];
   addr_t  order_q [IMAGE_SIZE];

   idx_t   idx_q;
   lvl_t   lvl_q;
   addr_t  sum_q;
   addr_t  nevents_q;
   addr_t  k_q;
   addr_t  addr_q;
   logic   abort_q;
   logic   req_q;
   logic   encoded_q;

   logic   ack_s;
   logic   idx_last;
   logic   lvl_last;
   logic   emit_done;
   logic   hist_clr;
   pixel_t pix_cur;
   lvl_t   pix_lvl;

   aer_ack_sync u_ack_sync (
      .clk_i  (CLK),
      .rst_ni (RST),
      .ack_i  (AERIN_ACK),
      .ack_o  (ack_s)
   );

   assign pix_cur   = pix_q[idx_q];
   assign pix_lvl   = pix_cur[CIDX_W-1:0];
   assign idx_last  = (idx_q == idx_t'(IMAGE_SIZE - 1));
   assign lvl_last  = (lvl_q == lvl_t'(1));
   assign emit_done = (k_q == nevents_q);

   always_comb begin
      state_d  = state_q;
      hist_clr = 1'b0;
      case (state_q)
         IDLE:        if (NEW_IMAGE) state_d = HIST;
         HIST:        if (INFERENCE_DONE) state_d = IDLE;
                      else if (idx_last) state_d = PREFIX;
         PREFIX:      if (INFERENCE_DONE) state_d = IDLE;
                      else if (lvl_last) state_d = PLACE;
         PLACE:       if (INFERENCE_DONE) state_d = IDLE;
                      else if (idx_last) state_d = DONE_SORT;
         DONE_SORT:   state_d = INFERENCE_DONE ? IDLE : EMIT;
         EMIT:        state_d = (INFERENCE_DONE || emit_done) ? IDLE : WAIT_ACK_HI;
         WAIT_ACK_HI: if (ack_s) state_d = WAIT_ACK_LO;
         WAIT_ACK_LO: if (!ack_s) state_d = (abort_q || INFERENCE_DONE) ? IDLE : EMIT;
         default:     state_d = IDLE;
      endcase
      // The histogram must be empty before the next HIST pass on every exit path.
      if (state_q == DONE_SORT) hist_clr = 1'b1;
      if (INFERENCE_DONE && (state_q inside {HIST, PREFIX, PLACE, EMIT})) hist_clr = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         lvl_q     <= '0;
         sum_q     <= '0;
         nevents_q <= '0;
         k_q       <= '0;
         addr_q    <= '0;
         abort_q   <= 1'b0;
         req_q     <= 1'b0;
         encoded_q <= 1'b0;
         for (int v = 0; v <= PIXEL_MAX_VALUE; v++) count_q[v] <= '0;
      end else begin
         state_q   <= state_d;
         encoded_q <= (state_d == DONE_SORT);

         if (hist_clr) begin
            for (int v = 0; v <= PIXEL_MAX_VALUE; v++) count_q[v] <= '0;
         end else if (state_q == HIST) begin
            count_q[pix_lvl] <= count_q[pix_lvl] + addr_t'(1);
         end

         case (state_q)
            IDLE: idx_q <= '0;
            HIST: begin
               idx_q <= idx_q + idx_t'(1);
               lvl_q <= lvl_t'(PIXEL_MAX_VALUE);
               sum_q <= '0;
            end
            PREFIX: begin
               sum_q <= sum_q + count_q[lvl_q];
               lvl_q <= lvl_q - lvl_t'(1);
               if (lvl_last) nevents_q <= addr_t'(IMAGE_SIZE) - count_q[0];
            end
            PLACE:     idx_q <= idx_q + idx_t'(1);
            DONE_SORT: k_q   <= '0;
            EMIT: begin
               if (state_d == WAIT_ACK_HI) begin
                  req_q  <= 1'b1;
                  addr_q <= order_q[k_q[IMAGE_SIZE_BITS-1:0]];
               end
            end
            WAIT_ACK_HI: begin
               if (INFERENCE_DONE) abort_q <= 1'b1;
               if (ack_s) req_q <= 1'b0;
            end
            WAIT_ACK_LO: begin
               if (INFERENCE_DONE) abort_q <= 1'b1;
               if (!ack_s) k_q <= k_q + addr_t'(1);
            end
            default: ;
         endcase

         if (state_d == IDLE) abort_q <= 1'b0;
      end
   end

   // Sort buffers carry no reset: they are fully rewritten before being read.
   always_ff @(posedge CLK) begin
      if (state_q == IDLE && NEW_IMAGE) pix_q <= IMAGE;
      if (state_q == PREFIX) start_q[lvl_q] <= sum_q;
      if (state_q == PLACE && pix_cur != '0) begin
         order_q[start_q[pix_lvl][IMAGE_SIZE_BITS-1:0]] <= addr_t'(idx_q);
         start_q[pix_lvl] <= start_q[pix_lvl] + addr_t'(1);
      end
   end

   assign IMAGE_ENCODED = encoded_q;
   assign AERIN_ADDR    = addr_q;
   assign AERIN_REQ     = req_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rank_order_encoder.sv
// Directed bench for rank_order_encoder with an ACK responder and a protocol monitor.
`timescale 1ns/1ps
module tb_rank_order_encoder;
   import encoder_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   pixel_t     img [IMAGE_SIZE];
   logic       new_image;
   logic       inference_done;
   logic       image_encoded;
   addr_t      aerin_addr;
   logic       aerin_req;
   logic       aerin_ack = 1'b0;
   enc_state_e dbg_state;

   always #2 clk = ~clk;

   rank_order_encoder dut (
      .CLK            (clk),
      .RST            (rst_n),
      .IMAGE          (img),
      .NEW_IMAGE      (new_image),
      .INFERENCE_DONE (inference_done),
      .IMAGE_ENCODED  (image_encoded),
      .AERIN_ADDR     (aerin_addr),
      .AERIN_REQ      (aerin_req),
      .AERIN_ACK      (aerin_ack),
      .dbg_state_o    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int    n_checks = 0;
   int    n_pass   = 0;
   int    n_fail   = 0;
   addr_t exp_q[$];
   addr_t got_q[$];
   int    enc_cnt      = 0;
   int    enc_at_first = -1;
   int    ack_dly      = 101;
   int    ack_lo_dly   = 21;
   logic  req_prev     = 1'b0;
   logic  enc_prev     = 1'b0;
   addr_t addr_prev    = '0;
   int    ack_hi_cnt   = 0;
   int    lat;
   int    nz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- AER device model ----------------
   // Delays are odd multiples of 1 ns so ACK never changes on a clock edge.
   always begin
      @(posedge aerin_req);
      #(ack_dly);
      aerin_ack = 1'b1;
      wait (aerin_req == 1'b0);
      #(ack_lo_dly);
      aerin_ack = 1'b0;
   end

   // ---------------- protocol monitor ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (image_encoded) begin
            enc_cnt++;
            chk("enc_single_cycle", enc_prev, 0);
         end
         if (aerin_req && !req_prev) begin
            chk("ack_low_at_req_rise", aerin_ack, 0);
            if (got_q.size() == 0) enc_at_first = enc_cnt;
            got_q.push_back(aerin_addr);
         end
         if (aerin_req && req_prev) chk("addr_stable_while_req", aerin_addr, addr_prev);
         if (!aerin_req && req_prev) begin
            chk("ack_high_at_req_fall", aerin_ack, 1);
            chk("req_fall_within_3_cycles", (ack_hi_cnt <= 3), 1);
         end
         ack_hi_cnt = (aerin_req && aerin_ack) ? ack_hi_cnt + 1 : 0;
         req_prev   = aerin_req;
         addr_prev  = aerin_addr;
         enc_prev   = image_encoded;
      end else begin
         req_prev   = 1'b0;
         enc_prev   = 1'b0;
         ack_hi_cnt = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_img();
      for (int i = 0; i < IMAGE_SIZE; i++) img[i] = '0;
   endtask

   task automatic load_a();
      clear_img();
      img[3] = 9'd200; img[5] = 9'd200; img[10] = 9'd100;
   endtask

   task automatic start_image();
      got_q.delete();
      enc_cnt      = 0;
      enc_at_first = -1;
      @(negedge clk) new_image = 1'b1;
      @(negedge clk) new_image = 1'b0;
   endtask

   task automatic wait_enc(output int cycles);
      cycles = 0;
      while (enc_cnt == 0 && cycles < 1000) begin
         @(negedge clk);
         cycles++;
      end
      if (enc_cnt == 0) chk("encoded_timeout", enc_cnt, 1);
   endtask

   task automatic wait_events(input int n, input int budget);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (got_q.size() < n) chk("events_timeout", got_q.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (!(dbg_state == IDLE && !aerin_req && !aerin_ack) && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (c >= budget) chk("idle_timeout", dbg_state, IDLE);
   endtask

   task automatic check_events(input string tag);
      chk({tag, "_event_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_addr[%0d]", tag, i), got_q[i], exp_q[i]);
      chk({tag, "_enc_pulses"}, enc_cnt, 1);
      if (exp_q.size() > 0) chk({tag, "_enc_before_req"}, enc_at_first, 1);
   endtask

   task automatic run_image(input string tag, input int budget);
      start_image();
      wait_enc(lat);
      chk({tag, "_sort_latency"}, (lat >= 740 && lat <= 800), 1);
      wait_idle(budget);
      check_events(tag);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst_n          = 1'b0;
      new_image      = 1'b1;
      inference_done = 1'b0;
      load_a();
      repeat (4) @(negedge clk);
      chk("rst_req", aerin_req, 0);
      chk("rst_addr", aerin_addr, 0);
      chk("rst_enc", image_encoded, 0);
      chk("rst_state", dbg_state, IDLE);
      new_image = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_state", dbg_state, IDLE);
      chk("post_rst_req", aerin_req, 0);

      // Three non-zero pixels, tie at 200 resolved by lower index.
      load_a();
      exp_q = {9'd3, 9'd5, 9'd10};
      run_image("img_a", 3000);

      // Abort during HIST; the restart must see a clean histogram.
      load_a();
      start_image();
      repeat (50) @(negedge clk);
      inference_done = 1'b1;
      @(negedge clk) inference_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("hist_abort_state", dbg_state, IDLE);
      repeat (20) @(negedge clk);
      chk("hist_abort_no_enc", enc_cnt, 0);
      chk("hist_abort_no_req", got_q.size(), 0);
      clear_img();
      img[7] = 9'd9; img[2] = 9'd9; img[100] = 9'd50;
      exp_q = {9'd100, 9'd2, 9'd7};
      run_image("img_b", 3000);

      // All-zero image: pulse, no events.
      clear_img();
      exp_q.delete();
      run_image("zero", 200);

      // Ramp: 255 events, pixel 0 never emitted.
      ack_dly = 13;
      for (int i = 0; i < IMAGE_SIZE; i++) img[i] = pixel_t'(i);
      exp_q.delete();
      for (int v = 255; v >= 1; v--) exp_q.push_back(addr_t'(v));
      run_image("ramp", 20000);

      // Slow ACK: REQ and ADDR hold for the whole 1 us.
      ack_dly = 1001;
      load_a();
      exp_q = {9'd3, 9'd5, 9'd10};
      start_image();
      wait_enc(lat);
      wait_events(1, 100);
      repeat (200) @(negedge clk);
      chk("slow_req_held", aerin_req, 1);
      chk("slow_addr_held", aerin_addr, 3);
      chk("slow_ack_still_low", aerin_ack, 0);
      wait_idle(3000);
      check_events("slow");

      // Abort while REQ is up on the second event.
      ack_dly = 101;
      load_a();
      exp_q = {9'd3, 9'd5};
      start_image();
      wait_enc(lat);
      wait_events(2, 500);
      chk("abort_req_up", aerin_req, 1);
      inference_done = 1'b1;
      @(negedge clk) inference_done = 1'b0;
      wait_idle(500);
      repeat (50) @(negedge clk);
      check_events("abort_emit");
      chk("abort_emit_state", dbg_state, IDLE);
      chk("abort_emit_req", aerin_req, 0);

      // Restart with extreme IDs and values.
      clear_img();
      img[255] = 9'd1; img[0] = 9'd1; img[128] = 9'd255;
      exp_q = {9'd128, 9'd0, 9'd255};
      run_image("img_c", 3000);

      // Digit-like image with distinct peaks; NEW_IMAGE mid-emission ignored.
      ack_dly = 13;
      clear_img();
      for (int r = 2; r <= 13; r++)
         for (int c = 6; c <= 9; c++)
            img[r*16+c] = pixel_t'(60 + ((r*16+c)*37) % 170);
      img[120] = 9'd250; img[135] = 9'd243; img[104] = 9'd239;
      nz = 0;
      for (int i = 0; i < IMAGE_SIZE; i++) if (img[i] != '0) nz++;
      exp_q.delete();
      for (int v = 255; v >= 1; v--)
         for (int i = 0; i < IMAGE_SIZE; i++)
            if (img[i] == pixel_t'(v)) exp_q.push_back(addr_t'(i));
      start_image();
      wait_enc(lat);
      wait_events(5, 500);
      for (int i = 0; i < IMAGE_SIZE; i++) img[i] = 9'd1;
      @(negedge clk) new_image = 1'b1;
      @(negedge clk) new_image = 1'b0;
      wait_idle(5000);
      repeat (10) @(negedge clk);
      check_events("digit");
      chk("digit_nonzero_count", got_q.size(), nz);
      if (got_q.size() >= 3) begin
         chk("digit_first_250", got_q[0], 120);
         chk("digit_second_243", got_q[1], 135);
         chk("digit_third_239", got_q[2], 104);
      end
      chk("digit_idle_after", dbg_state, IDLE);

      // Asynchronous reset mid-emission.
      ack_dly = 101;
      load_a();
      start_image();
      wait_enc(lat);
      wait_events(1, 100);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_req", aerin_req, 0);
      chk("async_rst_addr", aerin_addr, 0);
      chk("async_rst_state", dbg_state, IDLE);
      chk("async_rst_enc", image_encoded, 0);
      repeat (40) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("async_rst_release_state", dbg_state, IDLE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rank_order_encoder.md
Name: rank_order_encoder

Overview:
- Rank-order spike encoder between the image source and the SNN core's AER input.
- Captures a 256-pixel image on NEW_IMAGE and orders pixel IDs by descending intensity using an internal counting sort.
- Emits one AER event per non-zero pixel, brightest first, over a 4-phase REQ/ACK link.
- INFERENCE_DONE aborts emission early.

Parameters:
- IMAGE_SIZE, 256: number of pixels.
- IMAGE_SIZE_BITS, 8: log2(IMAGE_SIZE). Address width is IMAGE_SIZE_BITS+1.
- PIXEL_MAX_VALUE, 255: largest pixel value.
- PIXEL_BITS, 8: ceil(log2(PIXEL_MAX_VALUE)). Pixel width is PIXEL_BITS+1; only values 0..PIXEL_MAX_VALUE are legal.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- IMAGE  in  [PIXEL_BITS:0] x IMAGE_SIZE (unpacked array)  pixel intensities; sampled only on NEW_IMAGE acceptance.
- NEW_IMAGE  in  1  start request, level-sampled in IDLE.
- INFERENCE_DONE  in  1  abort or stop emission.
- IMAGE_ENCODED  out  1  one-cycle pulse when sorting completes.
- AERIN_ADDR  out  [IMAGE_SIZE_BITS:0]  pixel ID of the current event.
- AERIN_REQ  out  1  AER request.
- AERIN_ACK  in  1  AER acknowledge; asynchronous, passes through a 2-flop synchronizer.

Behaviour:
- Reset state: AERIN_REQ=0, AERIN_ADDR=0, IMAGE_ENCODED=0, FSM in IDLE, histogram cleared, ACK synchronizer cleared.
- IDLE:
  - When NEW_IMAGE=1, latch all IMAGE pixels into an internal buffer and go to HIST.
  - NEW_IMAGE in any other state is ignored.
- HIST:
  - One pixel per cycle, i=0..IMAGE_SIZE-1: count[pix[i]]++.
  - count array has PIXEL_MAX_VALUE+1 entries, each IMAGE_SIZE_BITS+1 bits wide.
- PREFIX:
  - One level per cycle, v=PIXEL_MAX_VALUE down to 1: start[v] = running sum of count[w] for w>v.
  - nevents = IMAGE_SIZE - count[0].
- PLACE:
  - One pixel per cycle, i ascending: if pix[i]!=0, then order[start[pix[i]]] = i and start[pix[i]]++.
  - Result: descending intensity; ties resolved by lower index first.
  - Zero-valued pixels never produce events.
- DONE_SORT: IMAGE_ENCODED=1 for exactly one cycle, clear histogram, then go to EMIT (k=0).
- EMIT:
  - If k==nevents, return to IDLE.
  - Otherwise drive AERIN_ADDR=order[k] and AERIN_REQ=1 on the same edge; go to WAIT_ACK_HI.
  - ADDR stays stable while REQ=1.
- WAIT_ACK_HI: when synced ACK=1, drive REQ=0; go to WAIT_ACK_LO.
- WAIT_ACK_LO: when synced ACK=0, k++; go to EMIT. The next REQ is raised no earlier than the following cycle.
- INFERENCE_DONE=1:
  - In HIST, PREFIX, PLACE, DONE_SORT or EMIT: return to IDLE next cycle with REQ=0 and histogram cleared.
  - In WAIT_ACK_HI or WAIT_ACK_LO: latch an abort flag, finish the current 4-phase handshake (never drop REQ before ACK), then go to IDLE.
  - In IDLE: no effect.
- All-zero image: IMAGE_ENCODED pulses, no REQ ever, return to IDLE.
- Sort latency: about 3*IMAGE_SIZE cycles from NEW_IMAGE to the IMAGE_ENCODED pulse.
- No wrap-around: each ID is emitted at most once per image.
- An asynchronous reset mid-operation returns everything to the reset state immediately.

Decomposition:
- Shared package encoder_pkg holds:
  - the default size constants;
  - the FSM state enum (IDLE, HIST, PREFIX, PLACE, DONE_SORT, EMIT, WAIT_ACK_HI, WAIT_ACK_LO);
  - pixel_t and addr_t typedefs.
- One sub-module, aer_ack_sync: a 2-flop synchronizer for AERIN_ACK with async active-low reset.
- Histogram, start, order and pixel buffers are inferred register arrays inside rank_order_encoder.

Test Plan:
- Reset held low with NEW_IMAGE=1 → REQ=0, ADDR=0, IMAGE_ENCODED=0. After release with NEW_IMAGE=0 → still idle.
- Image all 0 except pix[3]=200, pix[5]=200, pix[10]=100, bench acking after 100 ns → exactly 3 events with ADDR 3, 5, 10 in that order, one IMAGE_ENCODED pulse preceding the first REQ, then return to IDLE.
- Ramp pix[i]=i (i=0..255) → 255 events, ADDR 255 down to 1, pixel 0 never emitted.
- Slow/no-ACK check: bench delays ACK 1 µs → REQ stays high and ADDR stays stable until ACK. REQ falls within 3 cycles of ACK rise. No new REQ until ACK has been seen low.
- INFERENCE_DONE pulse (4 ns) while REQ=1 on the 2nd event → that handshake completes, no further REQ, FSM back in IDLE. A later NEW_IMAGE restarts correctly with a fresh histogram.
- Full 16x16 digit image (peak values 250, 243, 239, ...) → first ADDRs are the IDs of 250, 243 and 239 in that order. Event count equals the number of non-zero pixels. NEW_IMAGE pulsed mid-emission is ignored.
